// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the single-bus CPU datapath:
// widths, ALU op bit positions and bus driver selects.
package cpu_datapath_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;
    localparam int IDXW  = $clog2(NREGS);
    localparam int NOPS  = 12;

    localparam int OP_AND = 0;
    localparam int OP_OR  = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_MUL = 4;
    localparam int OP_DIV = 5;
    localparam int OP_SHR = 6;
    localparam int OP_SHL = 7;
    localparam int OP_ROR = 8;
    localparam int OP_ROL = 9;
    localparam int OP_NEG = 10;
    localparam int OP_NOT = 11;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PC,
        SEL_ZHI,
        SEL_ZLO,
        SEL_MDR,
        SEL_REG
    } bus_sel_e;

endpackage

// File: rtl/cpu_datapath_if.sv
// Control strobes, memory data and observation outputs
// between the control unit (master) and the datapath (slave).
interface cpu_datapath_if;
    import cpu_datapath_pkg::*;

    logic [NREGS-1:0]            reg_out;
    logic [NREGS-1:0]            reg_in;
    logic                        PCout;
    logic                        Zhiout;
    logic                        Zlowout;
    logic                        MDRout;
    logic                        PCin;
    logic                        IRin;
    logic                        MARin;
    logic                        MDRin;
    logic                        Yin;
    logic                        Zin;
    logic                        IncPC;
    logic                        Read;
    logic [WIDTH-1:0]            Mdatain;
    logic [NOPS-1:0]             alu_op;
    logic signed [2*WIDTH-1:0]   outp;
    logic [WIDTH-1:0]            mar_q;
    logic [WIDTH-1:0]            ir_q;

    modport master (
        output reg_out, reg_in, PCout, Zhiout, Zlowout, MDRout,
        output PCin, IRin, MARin, MDRin, Yin, Zin,
        output IncPC, Read, Mdatain, alu_op,
        input  outp, mar_q, ir_q
    );

    modport slave (
        input  reg_out, reg_in, PCout, Zhiout, Zlowout, MDRout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin,
        input  IncPC, Read, Mdatain, alu_op,
        output outp, mar_q, ir_q
    );

endinterface

// File: rtl/cpu_datapath_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit {hi, lo} result.
// Lowest set op bit wins; IncPC overrides every op.
module cpu_alu
    import cpu_datapath_pkg::*;
(
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [NOPS-1:0]    i_op,
    input  logic               i_inc,
    output logic [2*WIDTH-1:0] o_res
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic signed [WIDTH-1:0]   w_sa;
    logic signed [WIDTH-1:0]   w_sb;
    logic signed [2*WIDTH-1:0] w_ea;
    logic signed [2*WIDTH-1:0] w_eb;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0]        w_dbl;
    logic [2*WIDTH-1:0]        w_rr;
    logic [2*WIDTH-1:0]        w_rl;
    logic [4:0]                w_sh;

    assign w_sa   = i_a;
    assign w_sb   = i_b;
    assign w_ea   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_eb   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_prod = w_ea * w_eb;
    assign w_sh   = i_b[4:0];
    assign w_dbl  = {i_a, i_a};
    assign w_rr   = w_dbl >> w_sh;
    assign w_rl   = w_dbl << w_sh;

    // Result select; divide by zero yields {A, all ones}
    always_comb begin
        o_res = '0;
        if (i_inc) begin
            o_res = {ZERO, i_b + 32'd1};
        end else begin
            priority case (1'b1)
                i_op[OP_AND]: o_res = {ZERO, i_a & i_b};
                i_op[OP_OR]:  o_res = {ZERO, i_a | i_b};
                i_op[OP_ADD]: o_res = {ZERO, i_a + i_b};
                i_op[OP_SUB]: o_res = {ZERO, i_a - i_b};
                i_op[OP_MUL]: o_res = w_prod;
                i_op[OP_DIV]: begin
                    if (i_b == ZERO)
                        o_res = {i_a, ONES};
                    else
                        o_res = {w_sa % w_sb, w_sa / w_sb};
                end
                i_op[OP_SHR]: o_res = {ZERO, i_a >> w_sh};
                i_op[OP_SHL]: o_res = {ZERO, i_a << w_sh};
                i_op[OP_ROR]: o_res = {ZERO, w_rr[WIDTH-1:0]};
                i_op[OP_ROL]: o_res = {ZERO, w_rl[2*WIDTH-1:WIDTH]};
                i_op[OP_NEG]: o_res = {ZERO, -i_b};
                i_op[OP_NOT]: o_res = {ZERO, ~i_b};
                default:      o_res = '0;
            endcase
        end
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus datapath: GPRs, PC, IR, MAR, MDR, Y, Z and bus mux.
// Bus priority: PC > Zhi > Zlo > MDR > R0..R15 (lowest index).
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic           clock,
    input  logic           clear,
    cpu_datapath_if.slave  dp
);

    logic [WIDTH-1:0]   r_gpr [NREGS];
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_ir;
    logic [WIDTH-1:0]   r_mar;
    logic [WIDTH-1:0]   r_mdr;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_zhi;
    logic [WIDTH-1:0]   r_zlo;

    bus_sel_e           w_sel;
    logic [IDXW-1:0]    w_idx;
    logic [WIDTH-1:0]   w_bus;
    logic [2*WIDTH-1:0] w_res;

    // Pick the bus driver; later assignments take priority
    always_comb begin
        w_sel = SEL_NONE;
        w_idx = '0;
        for (int k = NREGS - 1; k >= 0; k--) begin
            if (dp.reg_out[k]) begin
                w_sel = SEL_REG;
                w_idx = k[IDXW-1:0];
            end
        end
        if (dp.MDRout)  w_sel = SEL_MDR;
        if (dp.Zlowout) w_sel = SEL_ZLO;
        if (dp.Zhiout)  w_sel = SEL_ZHI;
        if (dp.PCout)   w_sel = SEL_PC;
    end

    // Drive the bus from the selected source, zero when undriven
    always_comb begin
        w_bus = '0;
        case (w_sel)
            SEL_PC:  w_bus = r_pc;
            SEL_ZHI: w_bus = r_zhi;
            SEL_ZLO: w_bus = r_zlo;
            SEL_MDR: w_bus = r_mdr;
            SEL_REG: w_bus = r_gpr[w_idx];
            default: w_bus = '0;
        endcase
    end

    cpu_alu u_alu (
        .i_a   (r_y),
        .i_b   (w_bus),
        .i_op  (dp.alu_op),
        .i_inc (dp.IncPC),
        .o_res (w_res)
    );

    // Register file and special registers, all loaded from pre-edge bus
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int k = 0; k < NREGS; k++)
                r_gpr[k] <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_zhi <= '0;
            r_zlo <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++)
                if (dp.reg_in[k]) r_gpr[k] <= w_bus;
            if (dp.PCin)  r_pc  <= w_bus;
            if (dp.IRin)  r_ir  <= w_bus;
            if (dp.MARin) r_mar <= w_bus;
            if (dp.MDRin) r_mdr <= dp.Read ? dp.Mdatain : w_bus;
            if (dp.Yin)   r_y   <= w_bus;
            if (dp.Zin)   {r_zhi, r_zlo} <= w_res;
        end
    end

    assign dp.outp  = {r_zhi, r_zlo};
    assign dp.mar_q = r_mar;
    assign dp.ir_q  = r_ir;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath with an expected-value queue;
// registers are observed by routing them onto the bus into MAR.
module tb_cpu_datapath;
    import cpu_datapath_pkg::*;

    localparam int K_OUTP = 0;
    localparam int K_MAR  = 1;
    localparam int K_IR   = 2;

    typedef struct {
        string       tag;
        logic [63:0] exp;
        int          kind;
    } sb_t;

    logic clock;
    logic clear;
    int   vectors;
    int   miscompares;
    sb_t  q[$];

    cpu_datapath_if dp_if ();

    cpu_datapath dut (
        .clock (clock),
        .clear (clear),
        .dp    (dp_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        dp_if.reg_out = '0;
        dp_if.reg_in  = '0;
        dp_if.PCout   = 1'b0;
        dp_if.Zhiout  = 1'b0;
        dp_if.Zlowout = 1'b0;
        dp_if.MDRout  = 1'b0;
        dp_if.PCin    = 1'b0;
        dp_if.IRin    = 1'b0;
        dp_if.MARin   = 1'b0;
        dp_if.MDRin   = 1'b0;
        dp_if.Yin     = 1'b0;
        dp_if.Zin     = 1'b0;
        dp_if.IncPC   = 1'b0;
        dp_if.Read    = 1'b0;
        dp_if.Mdatain = '0;
        dp_if.alu_op  = '0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic push(input string tag, input logic [63:0] e,
                        input int kind);
        sb_t s;
        s.tag  = tag;
        s.exp  = e;
        s.kind = kind;
        q.push_back(s);
    endtask

    task automatic check();
        sb_t         s;
        logic [63:0] obs;
        s = q.pop_front();
        case (s.kind)
            K_MAR:   obs = {32'h0, dp_if.mar_q};
            K_IR:    obs = {32'h0, dp_if.ir_q};
            default: obs = dp_if.outp;
        endcase
        vectors++;
        assert (obs === s.exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", s.tag, obs, s.exp);
        end
    endtask

    task automatic mem2reg(input int k, input logic [31:0] v);
        dp_if.Mdatain = v;
        dp_if.Read    = 1'b1;
        dp_if.MDRin   = 1'b1;
        cyc();
        dp_if.MDRout    = 1'b1;
        dp_if.reg_in[k] = 1'b1;
        cyc();
    endtask

    task automatic peek(input int k, input string tag,
                        input logic [31:0] v);
        push(tag, {32'h0, v}, K_MAR);
        dp_if.reg_out[k] = 1'b1;
        dp_if.MARin      = 1'b1;
        cyc();
        check();
    endtask

    task automatic sety(input int k);
        dp_if.reg_out[k] = 1'b1;
        dp_if.Yin        = 1'b1;
        cyc();
    endtask

    task automatic aluop(input int op, input int k, input string tag,
                         input logic [63:0] v);
        push(tag, v, K_OUTP);
        if (k >= 0) dp_if.reg_out[k] = 1'b1;
        dp_if.alu_op[op] = 1'b1;
        dp_if.Zin        = 1'b1;
        cyc();
        check();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;

        // reset: preload, then async clear mid-cycle
        mem2reg(2, 32'd12);
        dp_if.Mdatain = 32'd5;
        dp_if.Read    = 1'b1;
        dp_if.MDRin   = 1'b1;
        cyc();
        dp_if.MDRout = 1'b1;
        dp_if.PCin   = 1'b1;
        dp_if.IRin   = 1'b1;
        dp_if.MARin  = 1'b1;
        cyc();
        push("z_pre", 64'd13, K_OUTP);
        dp_if.reg_out[2] = 1'b1;
        dp_if.IncPC      = 1'b1;
        dp_if.Zin        = 1'b1;
        cyc();
        check();
        #2;
        push("rst_outp", 64'd0, K_OUTP);
        push("rst_mar", 64'd0, K_MAR);
        push("rst_ir", 64'd0, K_IR);
        clear = 1'b0;
        #1;
        check();
        check();
        check();
        #1;
        clear = 1'b1;
        peek(2, "rst_r2", 32'd0);
        push("rst_pc", 64'd0, K_MAR);
        dp_if.PCout = 1'b1;
        dp_if.MARin = 1'b1;
        cyc();
        check();
        aluop(OP_OR, -1, "rst_y", 64'd0);

        // OR sequence
        mem2reg(2, 32'd12);
        mem2reg(4, 32'd15);
        mem2reg(5, 32'd10);
        sety(2);
        aluop(OP_OR, 4, "or", 64'd15);
        dp_if.Zlowout   = 1'b1;
        dp_if.reg_in[5] = 1'b1;
        cyc();
        peek(5, "or_r5", 32'd15);

        // fetch
        push("fetch_mar", 64'd0, K_MAR);
        push("fetch_z", 64'd1, K_OUTP);
        dp_if.PCout = 1'b1;
        dp_if.MARin = 1'b1;
        dp_if.IncPC = 1'b1;
        dp_if.Zin   = 1'b1;
        cyc();
        check();
        check();
        dp_if.Zlowout = 1'b1;
        dp_if.PCin    = 1'b1;
        dp_if.Read    = 1'b1;
        dp_if.MDRin   = 1'b1;
        dp_if.Mdatain = 32'h1A92_0000;
        cyc();
        push("fetch_pc", 64'd1, K_MAR);
        dp_if.PCout = 1'b1;
        dp_if.MARin = 1'b1;
        cyc();
        check();
        push("fetch_ir", 64'h1A92_0000, K_IR);
        dp_if.MDRout = 1'b1;
        dp_if.IRin   = 1'b1;
        cyc();
        check();

        // arithmetic, Y = -7, bus = 3
        mem2reg(6, 32'hFFFF_FFF9);
        mem2reg(7, 32'd3);
        sety(6);
        aluop(OP_ADD, 7, "add", 64'h0000_0000_FFFF_FFFC);
        aluop(OP_SUB, 7, "sub", 64'h0000_0000_FFFF_FFF6);
        aluop(OP_MUL, 7, "mul", 64'hFFFF_FFFF_FFFF_FFEB);
        push("zhi_out", 64'hFFFF_FFFF, K_MAR);
        dp_if.Zhiout = 1'b1;
        dp_if.MARin  = 1'b1;
        cyc();
        check();
        aluop(OP_DIV, 7, "div", 64'hFFFF_FFFF_FFFF_FFFE);

        // shifts and unary ops, Y = 80000001, bus = 1
        mem2reg(8, 32'h8000_0001);
        mem2reg(9, 32'd1);
        sety(8);
        aluop(OP_SHR, 9, "shr", 64'h0000_0000_4000_0000);
        aluop(OP_SHL, 9, "shl", 64'h0000_0000_0000_0002);
        aluop(OP_ROR, 9, "ror", 64'h0000_0000_C000_0000);
        aluop(OP_ROL, 9, "rol", 64'h0000_0000_0000_0003);
        aluop(OP_NOT, -1, "not", 64'h0000_0000_FFFF_FFFF);
        aluop(OP_NEG, 9, "neg", 64'h0000_0000_FFFF_FFFF);
        dp_if.IncPC = 1'b1;
        aluop(OP_ADD, 9, "incpc_ovr", 64'd2);
        dp_if.alu_op[OP_SHL] = 1'b1;
        aluop(OP_SHR, 9, "op_prio", 64'h0000_0000_4000_0000);

        // edge cases
        mem2reg(10, 32'd9);
        sety(10);
        aluop(OP_DIV, 13, "div0", 64'h0000_0009_FFFF_FFFF);
        push("bus_prio", 64'd1, K_MAR);
        dp_if.PCout  = 1'b1;
        dp_if.MDRout = 1'b1;
        dp_if.MARin  = 1'b1;
        cyc();
        check();
        push("reg_prio", 64'd12, K_MAR);
        dp_if.reg_out[4] = 1'b1;
        dp_if.reg_out[2] = 1'b1;
        dp_if.MARin      = 1'b1;
        cyc();
        check();
        mem2reg(3, 32'd77);
        peek(3, "r3_pre", 32'd77);
        dp_if.reg_in[3] = 1'b1;
        cyc();
        peek(3, "no_drv", 32'd0);
        dp_if.Mdatain = 32'd55;
        dp_if.Read    = 1'b1;
        dp_if.MDRin   = 1'b1;
        cyc();
        dp_if.MDRout     = 1'b1;
        dp_if.reg_in[11] = 1'b1;
        dp_if.reg_in[12] = 1'b1;
        cyc();
        peek(11, "multi_r11", 32'd55);
        peek(12, "multi_r12", 32'd55);
        mem2reg(0, 32'd42);
        peek(0, "r0", 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath: 16 general registers, PC, IR, MAR, MDR, Y, a 64-bit Z result register and a combinational ALU.
- Sits under the control unit. Every transfer is driven by one-hot control strobes from the controller or bench.
- Memory read data enters through Mdatain. The full 64-bit Z register is exported on outp for observation.

Parameters:
- WIDTH, 32, bus/register width (Z is 2*WIDTH).
- NREGS, 16, number of general registers.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-low reset
- reg_out  in  NREGS  one-hot: general register Rk drives bus
- reg_in  in  NREGS  load bus into Rk
- PCout, Zhiout, Zlowout, MDRout  in  1 each  bus driver selects
- PCin, IRin, MARin, MDRin, Yin, Zin  in  1 each  register load enables
- IncPC  in  1  ALU computes bus+1, overriding alu_op
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus
- Mdatain  in  WIDTH  memory read data
- alu_op  in  12  one-hot, bit order: AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT (bit 0 = AND)
- outp  out  2*WIDTH signed  {Zhi, Zlo}
- mar_q  out  WIDTH  MAR contents (memory address)
- ir_q  out  WIDTH  IR contents (for the decoder)

Behaviour:
- Reset (clear=0, async): R0–R15, PC, IR, MAR, MDR, Y, Zhi, Zlo all cleared to 0, so outp=0. Release is synchronous to the next edge.
- Bus driver priority, fixed, when more than one select is high: PCout > Zhiout > Zlowout > MDRout > R0 … R15 (lowest index wins). No driver selected → bus = 0.
- All registers load on the rising clock edge when their enable is high. Loads use pre-edge values, so bus-to-register transfers are single-cycle.
- R0 is an ordinary register.
- Multiple reg_in bits may be high; all selected registers load.
- MDR: on MDRin, loads Mdatain if Read=1, otherwise the bus.
- ALU is combinational. Operand A = Y, operand B = bus. On Zin, {Zhi, Zlo} <= result64.
  - IncPC=1 → result = B+1 in Zlo, Zhi=0, regardless of alu_op.
  - AND, OR, NOT(B), NEG(−B, two's complement): Zlo = result, Zhi = 0.
  - ADD, SUB (A−B): 32-bit wrap-around, Zhi = 0.
  - SHR: logical right of A by B[4:0]. SHL: left of A by B[4:0]. ROR/ROL: rotate A by B[4:0]. Zhi = 0 for all four.
  - MUL: signed 32x32 → 64; Zhi = high word, Zlo = low word.
  - DIV: signed A/B. Zlo = quotient (truncate toward zero), Zhi = remainder (sign of A). B=0 → Zlo = all ones, Zhi = A.
  - Several alu_op bits high → lowest set bit wins.
  - No alu_op bit and no IncPC → result = 0.
- Z loads only on Zin. Zhiout/Zlowout drive its stored halves, never the live ALU value.
- IR and MAR are plain loadable registers. No decode is done in this block.

Decomposition:
- Shared package: WIDTH, NREGS, ALU op bit indices, bus-select priority constants.
- One natural sub-module: cpu_alu (combinational, 12 ops, 64-bit result).
- Registers and bus mux stay in the top level.

Test Plan:
1. Reset: preload R2=12, PC=5, Z nonzero; pulse clear low mid-cycle → every register and outp = 0 immediately, before the next edge.
2. OR sequence: Mdatain=12 Read MDRin → R2; 15 → R4; 10 → R5. Then R2out+Yin; R4out+OR+Zin; Zlowout+R5in → R5=15, outp=64'd15.
3. Fetch: PC=0. PCout+MARin+IncPC+Zin → MAR=0, Zlo=1. Zlowout+PCin with Read MDRin Mdatain=32'h1A920000 → PC=1, MDR=1A920000. MDRout+IRin → ir_q=32'h1A920000.
4. Arithmetic: Y=−7, bus=3. ADD → Zlo=−4. SUB → Zlo=−10. MUL → outp=−21. DIV → Zlo=−2, Zhi=−1.
5. Shifts/unary: Y=32'h80000001, bus=1. SHR → 40000000. SHL → 00000002. ROR → C0000000. ROL → 00000003. NOT(bus=0) → FFFFFFFF. NEG(bus=1) → FFFFFFFF.
6. Edges: DIV by 0 with Y=9 → Zlo=FFFFFFFF, Zhi=9. PCout and MDRout both high → bus = PC. No driver → bus = 0 (load into R3 gives 0).
